ddr_local_mem_responder: RTL
============================

Name: ddr_local_mem_responder

Overview:
- Synthesizable responder for the Altera DDR controller "local" interface: ready, rdata_valid, sized bursts, byte enables.
- Stands in for the DDR controller plus its memory on FPGA bring-up boards and in simulation.
- Drives the initiator-side DDR wrapper without a real DDR device.
- Backs requests with an on-chip 32-bit RAM and models calibration delay, read latency and busy periods.

Parameters:
- ADDR_WIDTH, 25: byte address space; the local word address is ADDR_WIDTH-2 bits.
- MEM_ADR_WIDTH, 12: implemented RAM depth is 2^MEM_ADR_WIDTH words; upper address bits are ignored (aliasing).
- READ_LATENCY, 4: cycles from read accept to first rdata_valid; must be at least 2.
- INIT_CYCLES, 16: post-reset cycles with ready low (calibration model).
- MAX_BURST, 64: largest accepted local_size.

Ports:
- local_clk_i  in  1  clock.
- local_rst_i  in  1  synchronous, active-high reset.
- local_reset_n_o  out  1  registered ~local_rst_i, fed to the initiator.
- local_init_done_o  out  1  high once INIT completes.
- local_address_i  in  ADDR_WIDTH-2  word address.
- local_write_req_i  in  1  write beat request.
- local_read_req_i  in  1  read request.
- local_burstbegin_i  in  1  first beat of a request.
- local_wdata_i  in  32  write data.
- local_be_i  in  4  byte enables, applied to writes only.
- local_size_i  in  7  burst length in words.
- local_ready_o  out  1  request/beat acceptance.
- local_rdata_o  out  32  read data.
- local_rdata_valid_o  out  1  read data qualifier.
- err_o  out  1  sticky protocol-error flag.

Behaviour:
- Reset values: ready 0, rdata_valid 0, rdata 0, err 0, init_done 0, local_reset_n_o 0; state INIT.
- RAM contents are not reset and persist across reset.
- A beat is accepted in any cycle with ready=1 and a request asserted.
- INIT: counts INIT_CYCLES with ready=0, then enters IDLE and sets init_done=1. init_done stays 1 until the next reset.
- IDLE: ready=1.
  - write_req accepted: write beat 0 at the address with be. Latch address and effective size.
    - Size 1 stays in IDLE.
    - Size greater than 1 goes to WR_BURST with beat count 1.
  - read_req accepted: latch address and effective size, go to RD_WAIT.
  - write_req and read_req in the same cycle: accept the write, drop the read, set err.
  - burstbegin is not required for acceptance in IDLE.
- Effective size: size 0 maps to 1; size above MAX_BURST is clipped to MAX_BURST and sets err.
- WR_BURST: ready=1.
  - Each cycle with write_req=1 writes wdata/be at latched address + beat count (modulo 2^MEM_ADR_WIDTH).
  - write_req low inserts a gap; no timeout.
  - After the last beat, return to IDLE.
  - burstbegin=1 with write_req: set err and restart as a new burst from the new address. That beat is beat 0.
  - read_req=1 in WR_BURST: ignored, set err.
- RD_WAIT: ready=0; count READ_LATENCY-1 cycles, then enter RD_DATA.
  - First rdata_valid appears exactly READ_LATENCY cycles after the accept cycle.
- RD_DATA: ready=0.
  - One word per cycle, rdata_valid=1 for exactly size consecutive cycles, with no gaps.
  - Words come from address+k, wrapping modulo 2^MEM_ADR_WIDTH.
  - After the last beat, ready returns to 1 on the next cycle (IDLE).
- Requests presented while ready=0 are ignored with no error. The initiator must hold them.
- rdata holds its last value when rdata_valid=0.
- RAM is synchronous read, one port, write byte-lane merge per be bit.
- Reset mid-burst aborts the burst immediately: no further rdata_valid, partial writes remain in RAM.

Optional Feature:
- DDR_RESP_STALL_EN defined:
  - A 16-bit LFSR (seed 16'hACE1, reloaded on reset) forces ready=0 in IDLE and WR_BURST whenever its 2 LSBs are 2'b00.
  - This models controller refresh/busy; stalled beats are not accepted.
  - The LFSR advances every cycle.
- Not defined: the LFSR is absent and ready behaves exactly as in Behaviour.

Decomposition:
- Shared package ddr_local_pkg:
  - state encoding INIT/IDLE/WR_BURST/RD_WAIT/RD_DATA;
  - LFSR seed/taps;
  - the size clip/normalise function, shared with the initiator.
- One sub-module, ddr_local_ram: single-port byte-enabled synchronous RAM, parameterised by depth. Keeps the FSM separate and allows vendor RAM substitution.

Test Plan:
- Init: release reset → ready=0 and init_done=0 for 16 cycles, then both 1; local_reset_n_o follows ~reset one cycle late.
- Single write/read: write 0xDEADBEEF be=4'hF @0x10; read size=1 @0x10 → rdata_valid exactly 4 cycles after accept, rdata=0xDEADBEEF, ready back high the next cycle.
- Byte enables: write 0x11223344 be=4'hF, then 0xAABBCCDD be=4'b0101 @0x20 → read returns 0x11BB33DD.
- Burst read with wrap: preload words 0..7 with values 0..7 (MEM_ADR_WIDTH=3); read size=4 @6 → 4 consecutive valids returning 6,7,0,1 with ready=0 throughout.
- Protocol errors:
  - write_req+read_req together → write lands, no rdata_valid, err=1;
  - size=100 → 64 beats returned, err=1;
  - err stays 1 until reset.
- Reset mid-read at beat 2 of size 8 → rdata_valid drops the next cycle and stays 0; after INIT, a reread returns the prior RAM data unchanged.

Source files
------------

// File: rtl/ddr_local_mem_responder_pkg.sv
// Shared definitions for the DDR "local" interface responder and its initiator:
// FSM encoding, busy-LFSR constants and burst-size normalisation.
package ddr_local_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_WR_BURST,
    ST_RD_WAIT,
    ST_RD_DATA
  } state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;  // Galois form of x^16+x^14+x^13+x^11+1

  typedef struct packed {
    logic       clipped;
    logic [6:0] len;
  } size_norm_t;

  // Size 0 means one word; anything above max_burst is clipped and flagged.
  function automatic size_norm_t norm_size(input logic [6:0] size, input logic [6:0] max_burst);
    size_norm_t r;
    r.clipped = 1'b0;
    r.len     = size;
    if (size == 7'd0) begin
      r.len = 7'd1;
    end else if (size > max_burst) begin
      r.len     = max_burst;
      r.clipped = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ddr_local_mem_responder_if.sv
// Altera DDR controller "local" request/response bus between initiator (master)
// and controller/responder (slave).
interface ddr_local_mem_responder_if #(
  parameter int ADDR_WIDTH = 25
);
  logic [ADDR_WIDTH-3:0] address;
  logic                  write_req;
  logic                  read_req;
  logic                  burstbegin;
  logic [31:0]           wdata;
  logic [3:0]            be;
  logic [6:0]            size;
  logic                  ready;
  logic [31:0]           rdata;
  logic                  rdata_valid;

  modport master (
    output address, write_req, read_req, burstbegin, wdata, be, size,
    input  ready, rdata, rdata_valid
  );

  modport slave (
    input  address, write_req, read_req, burstbegin, wdata, be, size,
    output ready, rdata, rdata_valid
  );
endinterface

// File: rtl/ddr_local_mem_responder_ram.sv
// Single-port 32-bit RAM with per-byte write enables and registered read data;
// kept standalone so a vendor macro can drop in.
module ddr_local_ram #(
  parameter int ADR_W = 12
) (
  input  logic             clk,
  input  logic [ADR_W-1:0] addr,
  input  logic             we,
  input  logic             re,
  input  logic [3:0]       be,
  input  logic [31:0]      wdata,
  output logic [31:0]      q
);
  logic [31:0] mem [2**ADR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (re) q <= mem[addr];
  end
endmodule

// File: rtl/ddr_local_mem_responder.sv
// DDR controller stand-in: answers the local interface from on-chip RAM with
// calibration delay and fixed read latency. Define DDR_RESP_STALL_EN for LFSR busy stalls.
module ddr_local_mem_responder
  import ddr_local_pkg::*;
#(
  parameter int ADDR_WIDTH    = 25,
  parameter int MEM_ADR_WIDTH = 12,
  parameter int READ_LATENCY  = 4,
  parameter int INIT_CYCLES   = 16,
  parameter int MAX_BURST     = 64
) (
  input  logic local_clk_i,
  input  logic local_rst_i,
  output logic local_reset_n_o,
  output logic local_init_done_o,
  output logic err_o,
  ddr_local_mem_responder_if.slave loc
);
  localparam int AW      = ADDR_WIDTH - 2;
  localparam int MW      = MEM_ADR_WIDTH;
  localparam int CNT_MAX = (INIT_CYCLES > MAX_BURST) ?
                           ((INIT_CYCLES > READ_LATENCY) ? INIT_CYCLES : READ_LATENCY) :
                           ((MAX_BURST > READ_LATENCY) ? MAX_BURST : READ_LATENCY);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [6:0] MAX_SZ = 7'(MAX_BURST);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [MW-1:0]    base_q, base_d;
  logic [6:0]       len_q, len_d;
  logic             err_q, err_d;
  logic             init_done_q, init_done_d;
  logic             rvalid_q;
  logic [31:0]      hold_q;

  logic             ready, stall;
  logic             ram_we, ram_re;
  logic [MW-1:0]    ram_addr, in_addr;
  logic [31:0]      ram_q;
  size_norm_t       nin;
  logic             unused_addr_bits;

  assign in_addr          = loc.address[MW-1:0];
  assign unused_addr_bits = ^loc.address[AW-1:MW];
  assign nin              = norm_size(loc.size, MAX_SZ);

`ifdef DDR_RESP_STALL_EN
  logic [15:0] lfsr_q;
  always_ff @(posedge local_clk_i) begin
    if (local_rst_i) lfsr_q <= LFSR_SEED;
    else             lfsr_q <= (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
  end
  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    base_d      = base_q;
    len_d       = len_q;
    err_d       = err_q;
    init_done_d = init_done_q;
    ready       = 1'b0;
    ram_we      = 1'b0;
    ram_re      = 1'b0;
    ram_addr    = base_q + MW'(cnt_q);

    unique case (state_q)
      ST_INIT: begin
        if (cnt_q == CNT_W'(INIT_CYCLES - 1)) begin
          state_d     = ST_IDLE;
          cnt_d       = '0;
          init_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_IDLE: begin
        ready = !stall;
        if (ready && loc.write_req) begin
          ram_we   = 1'b1;
          ram_addr = in_addr;
          base_d   = in_addr;
          len_d    = nin.len;
          if (nin.clipped || loc.read_req) err_d = 1'b1;
          if (nin.len != 7'd1) begin
            state_d = ST_WR_BURST;
            cnt_d   = CNT_W'(1);
          end
        end else if (ready && loc.read_req) begin
          base_d  = in_addr;
          len_d   = nin.len;
          cnt_d   = '0;
          state_d = ST_RD_WAIT;
          if (nin.clipped) err_d = 1'b1;
        end
      end

      ST_WR_BURST: begin
        ready = !stall;
        if (ready && loc.read_req) err_d = 1'b1;
        if (ready && loc.write_req) begin
          ram_we = 1'b1;
          if (loc.burstbegin) begin
            // Unexpected burstbegin: flag it and treat this beat as beat 0 of a new burst.
            ram_addr = in_addr;
            base_d   = in_addr;
            len_d    = nin.len;
            err_d    = 1'b1;
            if (nin.len == 7'd1) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = CNT_W'(1);
            end
          end else if (cnt_q == CNT_W'(len_q - 7'd1)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      // The RAM read issues one cycle before rdata_valid, so word 0 is fetched
      // in the last wait cycle and each data cycle prefetches the next word.
      ST_RD_WAIT: begin
        if (cnt_q == CNT_W'(READ_LATENCY - 2)) begin
          ram_re   = 1'b1;
          ram_addr = base_q;
          cnt_d    = '0;
          state_d  = ST_RD_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RD_DATA: begin
        if (cnt_q != CNT_W'(len_q - 7'd1)) begin
          ram_re   = 1'b1;
          ram_addr = base_q + MW'(cnt_q + CNT_W'(1));
          cnt_d    = cnt_q + CNT_W'(1);
        end else begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge local_clk_i) begin
    local_reset_n_o <= ~local_rst_i;
    if (local_rst_i) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      base_q      <= '0;
      len_q       <= 7'd1;
      err_q       <= 1'b0;
      init_done_q <= 1'b0;
      rvalid_q    <= 1'b0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      base_q      <= base_d;
      len_q       <= len_d;
      err_q       <= err_d;
      init_done_q <= init_done_d;
      rvalid_q    <= ram_re;
      if (rvalid_q) hold_q <= ram_q;
    end
  end

  ddr_local_ram #(.ADR_W(MW)) u_ram (
    .clk   (local_clk_i),
    .addr  (ram_addr),
    .we    (ram_we),
    .re    (ram_re),
    .be    (loc.be),
    .wdata (loc.wdata),
    .q     (ram_q)
  );

  assign loc.ready         = ready;
  assign loc.rdata_valid   = rvalid_q;
  assign loc.rdata         = rvalid_q ? ram_q : hold_q;
  assign err_o             = err_q;
  assign local_init_done_o = init_done_q;
endmodule
